// File: rtl/vga_timing_pkg.sv
// Shared types and default video-mode constants for the raster timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

  // SVGA 800x600@60, 40 MHz pixel clock
  localparam int  SVGA_H_ACTIVE = 800;
  localparam int  SVGA_H_FP     = 40;
  localparam int  SVGA_H_SYNC   = 128;
  localparam int  SVGA_H_BP     = 88;
  localparam int  SVGA_V_ACTIVE = 600;
  localparam int  SVGA_V_FP     = 1;
  localparam int  SVGA_V_SYNC   = 4;
  localparam int  SVGA_V_BP     = 23;
  localparam bit  SVGA_SYNC_POL = 1'b1;
  localparam int  SVGA_CW       = 11;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One raster axis: wrapping counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// wrap flags that the next step returns the counter to 0.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic [CW-1:0] len_active,
  input  logic [CW-1:0] len_fp,
  input  logic [CW-1:0] len_sync,
  input  logic [CW-1:0] len_bp,
  output logic [CW-1:0] count,
  output phase_t        phase,
  output logic          wrap
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] b_front, b_sync, b_back, last;
  logic [CW-1:0] count_nxt;
  phase_t        phase_nxt;

  // Region boundaries; modulo-2**CW arithmetic keeps last correct when total == 2**CW
  assign b_front = len_active;
  assign b_sync  = len_active + len_fp;
  assign b_back  = b_sync + len_sync;
  assign last    = b_back + len_bp - ONE;
  assign wrap    = (count == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= ACTIVE;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    count_nxt = count;
    phase_nxt = phase;
    if (step) begin
      count_nxt = wrap ? '0 : count + ONE;
      case (phase)
        ACTIVE:  if (count_nxt == b_front) phase_nxt = FRONT;
        FRONT:   if (count_nxt == b_sync)  phase_nxt = SYNC;
        SYNC:    if (count_nxt == b_back)  phase_nxt = BACK;
        BACK:    if (count_nxt == '0)      phase_nxt = ACTIVE;
        default: phase_nxt = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running raster timing generator: pixel/line counters, sync and blanking
// strobes, and one-cycle line/frame start pulses for a single video mode.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter bit SYNC_POL = SVGA_SYNC_POL,
  parameter int CW       = SVGA_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_len
    $error("vga_timing: every region length must be at least 1");
  end
  if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_bad_cw
    $error("vga_timing: CW too small for the line or frame total");
  end

  localparam logic [CW-1:0] HA = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HF = CW'(H_FP);
  localparam logic [CW-1:0] HS = CW'(H_SYNC);
  localparam logic [CW-1:0] HB = CW'(H_BP);
  localparam logic [CW-1:0] VA = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VF = CW'(V_FP);
  localparam logic [CW-1:0] VS = CW'(V_SYNC);
  localparam logic [CW-1:0] VB = CW'(V_BP);

  phase_t h_phase, v_phase;
  logic   h_wrap, v_wrap;

  timing_axis #(.CW(CW)) u_h (
    .clk(clk), .rst(rst), .step(en),
    .len_active(HA), .len_fp(HF), .len_sync(HS), .len_bp(HB),
    .count(hcount), .phase(h_phase), .wrap(h_wrap)
  );

  timing_axis #(.CW(CW)) u_v (
    .clk(clk), .rst(rst), .step(en & h_wrap),
    .len_active(VA), .len_fp(VF), .len_sync(VS), .len_bp(VB),
    .count(vcount), .phase(v_phase), .wrap(v_wrap)
  );

  // Strobes decode straight from the registered phases, so they align with the counts
  assign hblnk = (h_phase != ACTIVE);
  assign vblnk = (v_phase != ACTIVE);
  assign hsync = (h_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vsync = (v_phase == SYNC) ? SYNC_POL : ~SYNC_POL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= en & h_wrap;
      frame_start <= en & h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: SVGA instance plus a small active-low mode, checked
// every cycle against a counter-based reference model through per-DUT queues.
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic hs, vs, hb, vb, ls, fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [10:0] hcount_s, vcount_s;
  logic hsync_s, vsync_s, hblnk_s, vblnk_s, line_start_s, frame_start_s;
  logic [3:0]  hcount_m, vcount_m;
  logic hsync_m, vsync_m, hblnk_m, vblnk_m, line_start_m, frame_start_m;

  always #5 clk = ~clk;

  vga_timing dut_s (
    .clk(clk), .rst(rst), .en(en),
    .hcount(hcount_s), .vcount(vcount_s), .hsync(hsync_s), .vsync(vsync_s),
    .hblnk(hblnk_s), .vblnk(vblnk_s), .line_start(line_start_s), .frame_start(frame_start_s)
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .CW(4)
  ) dut_m (
    .clk(clk), .rst(rst), .en(en),
    .hcount(hcount_m), .vcount(vcount_m), .hsync(hsync_m), .vsync(vsync_m),
    .hblnk(hblnk_m), .vblnk(vblnk_m), .line_start(line_start_m), .frame_start(frame_start_m)
  );

  int errors = 0;
  int checks = 0;
  exp_t q_s[$];
  exp_t q_m[$];

  int sh, sv, mh, mv;
  bit sls, sfs, mls, mfs;
  int en_hi = 0;

  int hb_rise_h = -1, hs_first_h = -1, hs_cycles = 0;
  bit prev_hb = 1'b0;
  int fs_pos[$];

  function automatic exp_t mk(input int h, input int v, input bit ls, input bit fs,
                              input int ha, input int hf, input int hsn,
                              input int va, input int vf, input int vsn, input bit pol);
    exp_t e;
    e.h  = 11'(h);
    e.v  = 11'(v);
    e.hb = (h >= ha);
    e.vb = (v >= va);
    e.hs = (h >= ha + hf && h < ha + hf + hsn) ? pol : ~pol;
    e.vs = (v >= va + vf && v < va + vf + vsn) ? pol : ~pol;
    e.ls = ls;
    e.fs = fs;
    return e;
  endfunction

  task automatic adv(inout int h, inout int v, output bit ls, output bit fs,
                     input int ht, input int vt, input bit e);
    ls = 1'b0;
    fs = 1'b0;
    if (e) begin
      ls = (h == ht - 1);
      fs = ls && (v == vt - 1);
      h  = ls ? 0 : h + 1;
      if (ls) v = (v == vt - 1) ? 0 : v + 1;
    end
  endtask

  task automatic model_reset();
    sh = 0; sv = 0; mh = 0; mv = 0;
    sls = 0; sfs = 0; mls = 0; mfs = 0;
  endtask

  task automatic cyc(input bit e);
    @(negedge clk);
    en = e;
    @(posedge clk);
    if (e) en_hi++;
    adv(sh, sv, sls, sfs, 1056, 628, e);
    adv(mh, mv, mls, mfs, 8, 6, e);
    q_s.push_back(mk(sh, sv, sls, sfs, 800, 40, 128, 600, 1, 4, 1'b1));
    q_m.push_back(mk(mh, mv, mls, mfs, 4, 1, 2, 3, 1, 1, 1'b0));
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  exp_t es, as_, em, am;

  always @(negedge clk) begin
    if (q_s.size() > 0) begin
      es  = q_s.pop_front();
      as_ = {hcount_s, vcount_s, hsync_s, vsync_s, hblnk_s, vblnk_s, line_start_s, frame_start_s};
      checks++;
      if (as_ !== es) begin
        errors++;
        $display("FAIL sb_svga: got h=%0d v=%0d hs%b vs%b hb%b vb%b ls%b fs%b expected h=%0d v=%0d hs%b vs%b hb%b vb%b ls%b fs%b",
                 as_.h, as_.v, as_.hs, as_.vs, as_.hb, as_.vb, as_.ls, as_.fs,
                 es.h, es.v, es.hs, es.vs, es.hb, es.vb, es.ls, es.fs);
      end
      if (hblnk_s && !prev_hb && hb_rise_h < 0) hb_rise_h = int'(hcount_s);
      prev_hb = hblnk_s;
      if (hsync_s) begin
        if (hs_first_h < 0) hs_first_h = int'(hcount_s);
        hs_cycles++;
      end
    end
    if (q_m.size() > 0) begin
      em = q_m.pop_front();
      am = {7'd0, hcount_m, 7'd0, vcount_m, hsync_m, vsync_m, hblnk_m, vblnk_m, line_start_m, frame_start_m};
      checks++;
      if (am !== em) begin
        errors++;
        $display("FAIL sb_small: got h=%0d v=%0d hs%b vs%b hb%b vb%b ls%b fs%b expected h=%0d v=%0d hs%b vs%b hb%b vb%b ls%b fs%b",
                 am.h, am.v, am.hs, am.vs, am.hb, am.vb, am.ls, am.fs,
                 em.h, em.v, em.hs, em.vs, em.hb, em.vb, em.ls, em.fs);
      end
      if (frame_start_m) fs_pos.push_back(en_hi);
    end
  end

  initial begin
    int h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Run to hcount = 500, then assert reset asynchronously between edges
    repeat (500) cyc(1'b1);
    @(negedge clk);
    en = 1'b0;
    chk("pre_reset_hcount", int'(hcount_s), 500);
    chk("pre_reset_hblnk_small", int'(hblnk_m), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_hcount", int'(hcount_s), 0);
    chk("rst_vcount", int'(vcount_s), 0);
    chk("rst_hsync", int'(hsync_s), 0);
    chk("rst_vsync", int'(vsync_s), 0);
    chk("rst_hblnk_small", int'(hblnk_m), 0);
    chk("rst_hcount_small", int'(hcount_m), 0);
    chk("rst_hsync_small", int'(hsync_m), 1);
    chk("rst_vsync_small", int'(vsync_m), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Full horizontal line on the SVGA instance
    hb_rise_h = -1; hs_first_h = -1; hs_cycles = 0; prev_hb = 1'b0;
    cyc(1'b1);
    #1;
    chk("first_en_hcount", int'(hcount_s), 1);
    chk("first_en_no_line_start", int'(line_start_s), 0);
    repeat (1055) cyc(1'b1);
    #1;
    chk("wrap_hcount", int'(hcount_s), 0);
    chk("wrap_vcount", int'(vcount_s), 1);
    chk("wrap_line_start", int'(line_start_s), 1);
    chk("wrap_frame_start", int'(frame_start_s), 0);
    chk("hblnk_rise_at", hb_rise_h, 800);
    chk("hsync_first_at", hs_first_h, 840);
    chk("hsync_width", hs_cycles, 128);

    // Enable gating: 1,0,1,0 advances two pixels
    h0 = int'(hcount_s);
    cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0);
    #1;
    chk("gated_advance", int'(hcount_s), h0 + 2);

    // Pulse captured at a wrap lasts one cycle when en drops
    while (mh != 7) cyc(1'b1);
    cyc(1'b1);
    #1;
    chk("small_wrap_pulse", int'(line_start_m), 1);
    cyc(1'b0);
    #1;
    chk("small_pulse_dropped", int'(line_start_m), 0);
    chk("small_held_hcount", int'(hcount_m), 0);

    // Back-to-back small frames under random enable
    @(negedge clk);
    fs_pos.delete();
    for (int i = 0; i < 3000 && fs_pos.size() < 3; i++) cyc(1'(($urandom_range(0, 1))));
    @(negedge clk);
    #1;
    chk("frame_start_count", fs_pos.size(), 3);
    if (fs_pos.size() >= 3) begin
      chk("frame_spacing_1", fs_pos[1] - fs_pos[0], 48);
      chk("frame_spacing_2", fs_pos[2] - fs_pos[1], 48);
    end
    chk("queues_drained", q_s.size() + q_m.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
